// File: rtl/result_packer.sv
// result_packer: waits for a full warp of valid thread results, snapshots
// them, then streams them two-per-word into the host-bound FIFO while
// honouring the FIFO full flag.
module result_packer #(
    parameter int THREAD_NUMBER = 256,
    parameter int DATA_WIDTH    = 16
) (
    input  logic                            bus_clk,
    input  logic                            srst,
    input  logic                            start,
    input  logic [THREAD_NUMBER*DATA_WIDTH-1:0] out_data,
    input  logic [THREAD_NUMBER-1:0]        out_valid,
    input  logic                            send_full,
    output logic                            send_enabled,
    output logic [2*DATA_WIDTH-1:0]         send_data,
    output logic                            busy,
    output logic                            done
);

    localparam int WORDS = THREAD_NUMBER / 2;
    // Pointer is at least one bit wide so the two-thread build still has a register.
    localparam int PW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [PW-1:0] LAST_P = PW'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t          state_reg, state_next;
    logic            armed_reg, armed_next;
    logic [PW-1:0]   p_reg, p_next;
    logic            capture;

    // Snapshot bank, already arranged as outgoing words: odd thread in the upper half.
    logic [2*DATA_WIDTH-1:0] cap_word [WORDS];
    logic [2*DATA_WIDTH-1:0] snap_reg [WORDS];

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign cap_word[gi] = {out_data[(2*gi+1)*DATA_WIDTH +: DATA_WIDTH],
                                   out_data[(2*gi)*DATA_WIDTH +: DATA_WIDTH]};

            // Freeze this word on capture so later input changes cannot leak into the send.
            always_ff @(posedge bus_clk) begin
                if (capture) begin
                    snap_reg[gi] <= cap_word[gi];
                end
            end
        end
    endgenerate

    // Control registers: state, arm flag and word pointer.
    always_ff @(posedge bus_clk) begin
        if (srst) begin
            state_reg <= ST_IDLE;
            armed_reg <= 1'b0;
            p_reg     <= '0;
        end else begin
            state_reg <= state_next;
            armed_reg <= armed_next;
            p_reg     <= p_next;
        end
    end

    // Next-state and output decode; outputs are forced idle outside SEND/DONE.
    always_comb begin
        state_next   = state_reg;
        armed_next   = armed_reg;
        p_next       = p_reg;
        capture      = 1'b0;
        send_enabled = 1'b0;
        send_data    = '0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // Capture only uses the registered arm flag, so a start in the
                // same cycle as full validity delays capture by one cycle.
                if (armed_reg && (&out_valid)) begin
                    capture    = 1'b1;
                    armed_next = 1'b0;
                    p_next     = '0;
                    state_next = ST_SEND;
                end else if (start) begin
                    armed_next = 1'b1;
                end
            end
            ST_SEND: begin
                busy         = 1'b1;
                send_enabled = ~send_full;
                send_data    = snap_reg[p_reg];
                if (!send_full) begin
                    if (p_reg == LAST_P) begin
                        state_next = ST_DONE;
                    end else begin
                        p_next = p_reg + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_result_packer.sv
// tb_result_packer: scoreboard bench. Expected words are queued when a
// capture is set up and popped by a monitor on every FIFO write.
module tb_result_packer;

    localparam int TN = 256;
    localparam int NW = TN / 2;

    logic              bus_clk = 1'b0;
    logic              srst;
    logic              start;
    logic [TN*16-1:0]  out_data;
    logic [TN-1:0]     out_valid;
    logic              send_full;
    logic              send_enabled;
    logic [31:0]       send_data;
    logic              busy;
    logic              done;

    // Minimal two-thread instance
    logic              start2;
    logic [31:0]       out_data2;
    logic [1:0]        out_valid2;
    logic              send_full2;
    logic              send_enabled2;
    logic [31:0]       send_data2;
    logic              busy2;
    logic              done2;

    always #5 bus_clk = ~bus_clk;

    result_packer #(.THREAD_NUMBER(TN), .DATA_WIDTH(16)) dut (
        .bus_clk      (bus_clk),
        .srst         (srst),
        .start        (start),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .send_full    (send_full),
        .send_enabled (send_enabled),
        .send_data    (send_data),
        .busy         (busy),
        .done         (done)
    );

    result_packer #(.THREAD_NUMBER(2), .DATA_WIDTH(16)) dut2 (
        .bus_clk      (bus_clk),
        .srst         (srst),
        .start        (start2),
        .out_data     (out_data2),
        .out_valid    (out_valid2),
        .send_full    (send_full2),
        .send_enabled (send_enabled2),
        .send_data    (send_data2),
        .busy         (busy2),
        .done         (done2)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0] td [TN];
    logic [31:0] exp_q [$];

    int done_cnt = 0;
    int wr_cnt   = 0;
    int busy_cnt = 0;
    int last_len = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic set_data();
        for (int i = 0; i < TN; i++) out_data[16*i +: 16] = td[i];
    endtask

    task automatic push_expected();
        for (int k = 0; k < NW; k++) exp_q.push_back({td[2*k+1], td[2*k]});
    endtask

    task automatic wait_done(input int limit);
        int d0;
        bit seen;
        d0   = done_cnt;
        seen = 1'b0;
        for (int c = 0; c < limit && !seen; c++) begin
            step();
            if (done_cnt != d0) seen = 1'b1;
        end
        check("done_timeout", {31'd0, seen}, 32'd1);
    endtask

    // Scoreboard monitor: pops one expected word per accepted write.
    always @(negedge bus_clk) begin : mon
        logic [31:0] e;
        if (send_enabled === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_write", send_data, 32'hDEAD_DEAD);
            end else begin
                e = exp_q.pop_front();
                check("word", send_data, e);
            end
        end
        if (send_full === 1'b1) check("write_while_full", {31'd0, send_enabled}, 32'd0);
        if (busy !== 1'b1 && srst === 1'b0) check("idle_data_zero", send_data, 32'd0);
        if (busy === 1'b1) busy_cnt++;
        else busy_cnt = 0;
        if (done === 1'b1) begin
            done_cnt++;
            last_len = busy_cnt;
            $display("txn %0d complete: %0d busy cycles, %0d writes total", done_cnt, last_len, wr_cnt);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0;
        int d0;
        srst       = 1'b1;
        start      = 1'b0;
        out_valid  = '0;
        send_full  = 1'b0;
        start2     = 1'b0;
        out_data2  = '0;
        out_valid2 = '0;
        send_full2 = 1'b0;
        for (int i = 0; i < TN; i++) td[i] = '0;
        set_data();
        repeat (3) step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_wr_en", {31'd0, send_enabled}, 32'd0);
        check("rst_data", send_data, 32'd0);
        srst = 1'b0;

        // Basic transfer, thread i = i, with snapshot isolation and a stray start.
        for (int i = 0; i < TN; i++) td[i] = 16'(i);
        set_data();
        start = 1'b1;
        step();
        start = 1'b0;
        check("armed_not_busy", {31'd0, busy}, 32'd0);
        out_valid = '1;
        push_expected();
        w0 = wr_cnt;
        d0 = done_cnt;
        step();
        check("send_entry_busy", {31'd0, busy}, 32'd1);
        check("first_wr_en", {31'd0, send_enabled}, 32'd1);
        check("first_word", send_data, 32'h0001_0000);
        out_data = '1;
        repeat (50) step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(400);
        check("basic_len", last_len, 32'd129);
        check("basic_writes", wr_cnt - w0, NW);
        check("basic_done_once", done_cnt - d0, 32'd1);
        check("basic_queue_empty", exp_q.size(), 32'd0);
        w0 = wr_cnt;
        repeat (10) step();
        check("stray_start_busy", {31'd0, busy}, 32'd0);
        check("stray_start_writes", wr_cnt - w0, 32'd0);

        // Backpressure; start and full validity arrive in the same cycle.
        out_valid = '0;
        step();
        for (int i = 0; i < TN; i++) td[i] = 16'($urandom);
        set_data();
        start = 1'b1;
        out_valid = '1;
        push_expected();
        w0 = wr_cnt;
        step();
        start = 1'b0;
        check("arm_first_busy", {31'd0, busy}, 32'd0);
        step();
        check("bp_send_entry", {31'd0, busy}, 32'd1);
        repeat (10) step();
        send_full = 1'b1;
        #1;
        check("bp_wr_en_low", {31'd0, send_enabled}, 32'd0);
        repeat (5) step();
        send_full = 1'b0;
        wait_done(400);
        check("bp_len", last_len, 32'd134);
        check("bp_writes", wr_cnt - w0, NW);

        // Back-to-back arm, but thread 255 not yet valid: no capture.
        out_valid = '1;
        out_valid[TN-1] = 1'b0;
        for (int i = 0; i < TN; i++) td[i] = ~16'(i);
        set_data();
        start = 1'b1;
        w0 = wr_cnt;
        step();
        start = 1'b0;
        repeat (5) step();
        check("partial_valid_busy", {31'd0, busy}, 32'd0);
        check("partial_valid_writes", wr_cnt - w0, 32'd0);
        out_valid[TN-1] = 1'b1;
        push_expected();
        step();
        check("late_valid_capture", {31'd0, busy}, 32'd1);
        wait_done(400);
        check("late_len", last_len, 32'd129);
        check("late_writes", wr_cnt - w0, NW);

        // Reset in the middle of a transfer at word 40.
        for (int i = 0; i < TN; i++) td[i] = 16'(i) ^ 16'h5A5A;
        set_data();
        start = 1'b1;
        push_expected();
        w0 = wr_cnt;
        step();
        start = 1'b0;
        step();
        repeat (40) step();
        srst = 1'b1;
        d0 = done_cnt;
        step();
        srst = 1'b0;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_done", {31'd0, done}, 32'd0);
        check("rst_mid_wr_en", {31'd0, send_enabled}, 32'd0);
        check("rst_mid_writes", wr_cnt - w0, 32'd41);
        check("rst_mid_leftover", exp_q.size(), NW - 41);
        exp_q.delete();
        w0 = wr_cnt;
        repeat (10) step();
        check("rst_no_restart_busy", {31'd0, busy}, 32'd0);
        check("rst_no_restart_writes", wr_cnt - w0, 32'd0);
        check("rst_no_done", done_cnt - d0, 32'd0);

        // Two-thread configuration: one word then done; start during SEND ignored.
        out_data2  = {16'hBEEF, 16'h1234};
        start2     = 1'b1;
        step();
        start2     = 1'b0;
        out_valid2 = 2'b11;
        step();
        check("min_busy", {31'd0, busy2}, 32'd1);
        check("min_wr_en", {31'd0, send_enabled2}, 32'd1);
        check("min_word", send_data2, 32'hBEEF_1234);
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        check("min_done", {31'd0, done2}, 32'd1);
        check("min_done_no_write", {31'd0, send_enabled2}, 32'd0);
        step();
        check("min_idle_done", {31'd0, done2}, 32'd0);
        check("min_idle_busy", {31'd0, busy2}, 32'd0);
        repeat (3) step();
        check("min_no_second_txn", {31'd0, busy2}, 32'd0);
        check("min_idle_data", send_data2, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
